fpu_thread_arb: RTL and testbench
=================================

FPU_THREAD_ARB -- requirements
Module: fpu_thread_arb

Interface
REQ-001 The block SHALL have parameter NTHREADS, default 4, giving the number of hardware threads (legal range 1..16).
REQ-002 The block SHALL have parameter DW, default 32, giving the operand width of dfa/dfb.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  the single clock; every flop updates on its rising edge.
- clrn  in  1  reset; synchronous and active-low.
- req_valid  in  NTHREADS  per-thread request valid.
- req_ready  out  NTHREADS  per-thread slot can accept.
- req_fd  in  5*NTHREADS  destination FP register, one 5-bit field per thread (thread i at bits [5i+4:5i]).
- req_fc  in  3*NTHREADS  FPU op code, one 3-bit field per thread.
- req_wf  in  NTHREADS  FP register write enable, one bit per thread.
- req_dfa, req_dfb  in  DW*NTHREADS  operands, packed per thread like req_fd.
- out_valid  out  1  FPU issue valid.
- out_ready  in  1  FPU accepts the issue.
- out_tid  out  TW  issuing thread id; TW = max(1, clog2(NTHREADS)).
- out_fd (5), out_fc (3), out_wf (1), out_dfa (DW), out_dfb (DW)  out  issued bundle.

Function
REQ-004 Each thread SHALL own a one-entry holding slot; the handshake req_valid[i]&&req_ready[i] at a rising edge SHALL load that thread's bundle into slot i.
REQ-005 req_ready[i] SHALL be 1 when slot i is empty, or when slot i is granted and moves into the output register in the same cycle; simultaneous drain and refill of one slot is legal.
REQ-006 A round-robin arbiter SHALL grant among valid slots, searching from pointer rr_ptr upward with wrap-around from NTHREADS-1 to 0.
REQ-007 The output register SHALL load the granted slot when it is empty or when out_valid&&out_ready holds this cycle; it SHALL NOT load otherwise.
REQ-008 On each load, rr_ptr SHALL become (granted id + 1) mod NTHREADS; rr_ptr SHALL NOT change on any other cycle.
REQ-009 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-010 Minimum latency SHALL be 2 edges: request handshake at edge E0, out_valid=1 after edge E1.
REQ-011 Sustained throughput SHALL be one issue per cycle when out_ready=1 and at least one slot is valid.
REQ-012 With every thread continuously requesting, grants SHALL rotate 0,1,...,NTHREADS-1,0; starvation is forbidden.
REQ-013 With NTHREADS=1, the block SHALL always grant thread 0, and out_tid SHALL be 0.

Reset
REQ-014 When clrn=0 at a rising edge, the block SHALL clear all slot valids and out_valid, set rr_ptr=0, and set out_tid, out_fd, out_fc, out_wf, out_dfa and out_dfb to 0.
REQ-015 During reset, req_ready SHALL be all 0.
REQ-016 Reset asserted mid-operation SHALL discard buffered and in-flight requests without issuing them.

Configuration
REQ-017 When macro FPU_ARB_PERF_EN is defined, the block SHALL add the following:
- output grant_cnt, 16*NTHREADS bits: per-thread saturating counters incremented on each issue handshake of that thread.
- output stall_cnt, 16 bits: saturating counter of cycles with out_valid=1 and out_ready=0.
- all counters reset to 0.
REQ-018 When FPU_ARB_PERF_EN is undefined, those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-019 The shared package fpu_arb_pkg SHALL hold FD_W=5, FC_W=3, the default DW=32, and the typedef of the issue bundle (fd, fc, wf, dfa, dfb).
REQ-020 Round-robin selection SHALL be a sub-module, rr_arbiter, with inputs req vector and pointer, and outputs one-hot grant and binary id.

Verification
REQ-021 The bench SHALL cover reset: hold clrn=0 with req_valid=4'b1111 -> out_valid=0, req_ready=0, and after release the first grant is tid 0.
REQ-022 The bench SHALL cover rotation: all 4 threads valid, out_ready=1 -> out_tid sequence 0,1,2,3,0, one issue per cycle.
REQ-023 The bench SHALL cover backpressure: out_ready=0 for 5 cycles with tid 2 issued, dfa=32'h3F800000 -> outputs stable, req_ready[2] goes 0 once slot 2 is refilled, and no loss after out_ready=1.
REQ-024 The bench SHALL cover wrap and skip: only threads 3 and 1 valid, rr_ptr=2 -> grant 3, then 1, then 3.
REQ-025 The bench SHALL cover mid-operation reset: clrn=0 while out_valid=1 and 3 slots are full -> after release no stale issue appears and rr_ptr=0.
REQ-026 The bench SHALL cover counters with FPU_ARB_PERF_EN defined: 70000 issues from tid 1 -> grant_cnt[1]=16'hFFFF (saturated).

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FPU thread arbiter: field widths, default
// operand width and the issue bundle carried from a thread to the FPU.
package fpu_arb_pkg;

  localparam int unsigned FD_W   = 5;
  localparam int unsigned FC_W   = 3;
  localparam int unsigned DEF_DW = 32;

  typedef struct packed {
    logic [FD_W-1:0]   fd;
    logic [FC_W-1:0]   fc;
    logic              wf;
    logic [DEF_DW-1:0] dfa;
    logic [DEF_DW-1:0] dfb;
  } issue_bundle_t;

  // Thread-id width; a single thread still gets a 1-bit id.
  function automatic int unsigned tid_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_thread_arb_rr.sv
// Round-robin arbiter: grants the first requester at or above ptr,
// wrapping to index 0, and reports both one-hot and binary grant.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  // Two ordered passes (upper part from ptr, then the wrapped lower part)
  // keep every vector index a loop constant.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= 32'(ptr))) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i] && (i < 32'(ptr))) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = IW'(i);
      end
    end
  end

endmodule

// File: rtl/fpu_thread_arb.sv
// Multi-thread FPU issue arbiter: one holding slot per thread, a
// round-robin pick among full slots, and a single output register that
// holds steady under backpressure.
// Optional feature macro FPU_ARB_PERF_EN adds per-thread issue counters
// (grant_cnt) and a backpressure cycle counter (stall_cnt).
module fpu_thread_arb
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned DW       = DEF_DW,
  localparam int unsigned TW      = tid_w(NTHREADS)
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [NTHREADS-1:0]      req_valid,
  output logic [NTHREADS-1:0]      req_ready,
  input  logic [5*NTHREADS-1:0]    req_fd,
  input  logic [3*NTHREADS-1:0]    req_fc,
  input  logic [NTHREADS-1:0]      req_wf,
  input  logic [DW*NTHREADS-1:0]   req_dfa,
  input  logic [DW*NTHREADS-1:0]   req_dfb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TW-1:0]            out_tid,
  output logic [4:0]               out_fd,
  output logic [2:0]               out_fc,
  output logic                     out_wf,
  output logic [DW-1:0]            out_dfa,
`ifdef FPU_ARB_PERF_EN
  output logic [16*NTHREADS-1:0]   grant_cnt,
  output logic [15:0]              stall_cnt,
`endif
  output logic [DW-1:0]            out_dfb
);

  typedef struct packed {
    logic [FD_W-1:0] fd;
    logic [FC_W-1:0] fc;
    logic            wf;
    logic [DW-1:0]   dfa;
    logic [DW-1:0]   dfb;
  } slot_t;

  logic [NTHREADS-1:0] slot_v_q, slot_v_d;
  slot_t               slot_q [NTHREADS];
  slot_t               slot_d [NTHREADS];

  logic                out_v_q, out_v_d;
  slot_t               out_b_q, out_b_d;
  logic [TW-1:0]       out_tid_q, out_tid_d;
  logic [TW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NTHREADS-1:0] gnt;
  logic [TW-1:0]       gnt_id;
  logic                gnt_any;
  logic                load;
  logic                out_fire;
  slot_t               sel;

  rr_arbiter #(
    .N  (NTHREADS),
    .IW (TW)
  ) u_rr (
    .req    (slot_v_q),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  // Output-register load decision, granted-slot mux and pointer advance.
  always_comb begin
    out_fire  = out_v_q && out_ready;
    load      = gnt_any && (!out_v_q || out_ready);
    sel       = '0;
    for (int unsigned i = 0; i < NTHREADS; i++) begin
      if (gnt[i]) sel = slot_q[i];
    end
    out_v_d   = out_v_q;
    out_b_d   = out_b_q;
    out_tid_d = out_tid_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      out_v_d   = 1'b1;
      out_b_d   = sel;
      out_tid_d = gnt_id;
      rr_ptr_d  = (32'(gnt_id) == NTHREADS - 1) ? '0 : gnt_id + TW'(1);
    end else if (out_fire) begin
      out_v_d   = 1'b0;
    end
  end

  // Per-thread slot fill/drain; a slot being granted this cycle may refill at once.
  always_comb begin
    req_ready = '0;
    slot_v_d  = slot_v_q;
    for (int unsigned i = 0; i < NTHREADS; i++) begin
      slot_d[i]    = slot_q[i];
      req_ready[i] = clrn && (!slot_v_q[i] || (load && gnt[i]));
      if (load && gnt[i]) slot_v_d[i] = 1'b0;
      if (req_valid[i] && req_ready[i]) begin
        slot_v_d[i]   = 1'b1;
        slot_d[i].fd  = req_fd[FD_W*i +: FD_W];
        slot_d[i].fc  = req_fc[FC_W*i +: FC_W];
        slot_d[i].wf  = req_wf[i];
        slot_d[i].dfa = req_dfa[DW*i +: DW];
        slot_d[i].dfb = req_dfb[DW*i +: DW];
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      slot_v_q  <= '0;
      for (int unsigned i = 0; i < NTHREADS; i++) slot_q[i] <= '0;
      out_v_q   <= 1'b0;
      out_b_q   <= '0;
      out_tid_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      slot_v_q  <= slot_v_d;
      for (int unsigned i = 0; i < NTHREADS; i++) slot_q[i] <= slot_d[i];
      out_v_q   <= out_v_d;
      out_b_q   <= out_b_d;
      out_tid_q <= out_tid_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_tid   = out_tid_q;
  assign out_fd    = out_b_q.fd;
  assign out_fc    = out_b_q.fc;
  assign out_wf    = out_b_q.wf;
  assign out_dfa   = out_b_q.dfa;
  assign out_dfb   = out_b_q.dfb;

`ifdef FPU_ARB_PERF_EN
  logic [16*NTHREADS-1:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]            stall_cnt_q, stall_cnt_d;

  // Saturating issue counters per thread and stall-cycle counter.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < NTHREADS; i++) begin
      if (out_fire && (out_tid_q == TW'(i)) && (grant_cnt_q[16*i +: 16] != 16'hFFFF))
        grant_cnt_d[16*i +: 16] = grant_cnt_q[16*i +: 16] + 16'd1;
    end
    if (out_v_q && !out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_thread_arb.sv
// Self-checking bench for fpu_thread_arb (4 threads, 32-bit operands).
// Accepted requests are queued on a scoreboard and matched against issues.
module tb_fpu_thread_arb;
  import fpu_arb_pkg::*;

  localparam int NT = 4;
  localparam int W  = 32;

  logic              clk = 1'b0;
  logic              clrn;
  logic [NT-1:0]     req_valid, req_ready, req_wf;
  logic [5*NT-1:0]   req_fd;
  logic [3*NT-1:0]   req_fc;
  logic [W*NT-1:0]   req_dfa, req_dfb;
  logic              out_valid, out_ready, out_wf;
  logic [1:0]        out_tid;
  logic [4:0]        out_fd;
  logic [2:0]        out_fc;
  logic [W-1:0]      out_dfa, out_dfb;
`ifdef FPU_ARB_PERF_EN
  logic [16*NT-1:0]  grant_cnt;
  logic [15:0]       stall_cnt;
`endif

  fpu_thread_arb #(.NTHREADS(NT), .DW(W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fd    (req_fd),
    .req_fc    (req_fc),
    .req_wf    (req_wf),
    .req_dfa   (req_dfa),
    .req_dfb   (req_dfb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tid   (out_tid),
    .out_fd    (out_fd),
    .out_fc    (out_fc),
    .out_wf    (out_wf),
    .out_dfa   (out_dfa),
`ifdef FPU_ARB_PERF_EN
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt),
`endif
    .out_dfb   (out_dfb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            tid;
    issue_bundle_t b;
  } sb_t;

  int            checks;
  int            failures;
  issue_bundle_t cur [NT];
  int            seq [NT];
  logic [NT-1:0] hold;
  bit            sb_en;
  sb_t           sbq [$];
  issue_bundle_t ob;

  assign ob = {out_fd, out_fc, out_wf, out_dfa, out_dfb};

  function automatic issue_bundle_t mk(input int t, input int s);
    issue_bundle_t b;
    b.fd  = 5'(t * 7 + s);
    b.fc  = 3'(s + t);
    b.wf  = 1'(s + t);
    b.dfa = {8'(t), 24'(s)};
    b.dfb = b.dfa ^ 32'hA5A5_5A5A;
    return b;
  endfunction

  task automatic apply(input int i);
    req_fd[5*i +: 5]  = cur[i].fd;
    req_fc[3*i +: 3]  = cur[i].fc;
    req_wf[i]         = cur[i].wf;
    req_dfa[W*i +: W] = cur[i].dfa;
    req_dfb[W*i +: W] = cur[i].dfb;
  endtask

  // Oldest expected bundle for a thread, removed from the scoreboard.
  function automatic void sb_take(input int tid, output bit ok, output issue_bundle_t b);
    int idx;
    idx = -1;
    b   = '0;
    for (int k = 0; k < sbq.size(); k++)
      if (idx < 0 && sbq[k].tid == tid) idx = k;
    ok = (idx >= 0);
    if (ok) begin
      b = sbq[idx].b;
      sbq.delete(idx);
    end
  endfunction

  // One clock: record request handshakes, cross the edge, advance payloads.
  task automatic tick();
    logic [NT-1:0] acc;
    #1;
    acc = req_valid & req_ready & {NT{clrn}};
    for (int i = 0; i < NT; i++)
      if (acc[i] && sb_en) sbq.push_back('{tid: i, b: cur[i]});
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NT; i++) begin
      if (acc[i]) begin
        seq[i]++;
        cur[i] = mk(i, seq[i]);
        apply(i);
        if (!hold[i]) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    clrn      = 1'b0;
    req_valid = '0;
    hold      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
    sbq.delete();
  endtask

  task automatic test_reset();
    int exp[$];
    int n, first;
    bit ok;
    issue_bundle_t eb;
    clrn = 1'b0; out_ready = 1'b1; hold = '0; req_valid = '1;
    sbq.delete();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    end
    clrn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1111) begin failures++; $display("FAIL reset_release_ready: got %b want 1111", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_latency_early: got out_valid=%b want 0", out_valid); end
    exp = '{0, 1, 2, 3};
    n = 0; first = -1;
    for (int c = 0; c < 20 && n < exp.size(); c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        if (first < 0) first = c;
        checks++;
        if (out_tid !== 2'(exp[n])) begin failures++; $display("FAIL reset_seq_tid[%0d]: got %0d want %0d", n, out_tid, exp[n]); end
        sb_take(int'(out_tid), ok, eb);
        checks++;
        if (!ok || ob !== eb) begin failures++; $display("FAIL reset_seq_data[%0d]: got %h want %h", n, ob, eb); end
        n++;
      end
      tick();
    end
    checks++;
    if (n != exp.size()) begin failures++; $display("FAIL reset_seq_timeout: got %0d issues want %0d", n, exp.size()); end
    checks++;
    if (first != 1) begin failures++; $display("FAIL reset_latency: first issue at %0d want 1", first); end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL reset_sb_left: got %0d want 0", sbq.size()); end
  endtask

  task automatic test_rotation();
    int exp[$];
    int n, first, last;
    bit ok;
    issue_bundle_t eb;
    do_reset();
    hold = '1; req_valid = '1; out_ready = 1'b1;
    exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    n = 0; first = -1; last = -1;
    for (int c = 0; c < 30 && n < exp.size(); c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        if (first < 0) first = c;
        last = c;
        checks++;
        if (out_tid !== 2'(exp[n])) begin failures++; $display("FAIL rot_tid[%0d]: got %0d want %0d", n, out_tid, exp[n]); end
        sb_take(int'(out_tid), ok, eb);
        checks++;
        if (!ok || ob !== eb) begin failures++; $display("FAIL rot_data[%0d]: got %h want %h", n, ob, eb); end
        n++;
      end
      tick();
    end
    checks++;
    if (n != exp.size()) begin failures++; $display("FAIL rot_timeout: got %0d issues want %0d", n, exp.size()); end
    checks++;
    if (last - first != exp.size() - 1) begin failures++; $display("FAIL rot_rate: got span %0d want %0d", last - first, exp.size() - 1); end
    hold = '0; req_valid = '0;
    for (int c = 0; c < 30 && sbq.size() > 0; c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        sb_take(int'(out_tid), ok, eb);
        checks++;
        if (!ok || ob !== eb) begin failures++; $display("FAIL rot_drain: tid %0d got %h want %h", out_tid, ob, eb); end
      end
      tick();
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL rot_sb_left: got %0d want 0", sbq.size()); end
  endtask

  task automatic test_backpressure();
    int exp[$];
    int n;
    bit ok;
    issue_bundle_t eb, held;
    do_reset();
    out_ready = 1'b0;
    cur[2].dfa = 32'h3F80_0000;
    apply(2);
    req_valid[2] = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tid !== 2'd2 || out_dfa !== 32'h3F80_0000) begin
      failures++; $display("FAIL bp_first: got v=%b tid=%0d dfa=%h want 1/2/3f800000", out_valid, out_tid, out_dfa);
    end
    held = ob;
    req_valid[2] = 1'b1;
    #1;
    checks++;
    if (req_ready[2] !== 1'b1) begin failures++; $display("FAIL bp_ready_empty: got %b want 1", req_ready[2]); end
    tick();
    req_valid[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready[2] !== 1'b0) begin failures++; $display("FAIL bp_ready_full[%0d]: got %b want 0", c, req_ready[2]); end
      checks++;
      if (out_valid !== 1'b1 || out_tid !== 2'd2 || ob !== held) begin
        failures++; $display("FAIL bp_stable[%0d]: got v=%b tid=%0d %h want 1/2 %h", c, out_valid, out_tid, ob, held);
      end
      tick();
    end
    out_ready = 1'b1;
    exp = '{2, 2, 2};
    n = 0;
    for (int c = 0; c < 20 && n < exp.size(); c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_tid !== 2'(exp[n])) begin failures++; $display("FAIL bp_tid[%0d]: got %0d want %0d", n, out_tid, exp[n]); end
        sb_take(int'(out_tid), ok, eb);
        checks++;
        if (!ok || ob !== eb) begin failures++; $display("FAIL bp_data[%0d]: got %h want %h", n, ob, eb); end
        n++;
      end
      tick();
    end
    checks++;
    if (n != exp.size()) begin failures++; $display("FAIL bp_timeout: got %0d issues want %0d", n, exp.size()); end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL bp_lost: got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_wrap_skip();
    int exp[$];
    int n;
    bit ok;
    issue_bundle_t eb;
    do_reset();
    out_ready = 1'b1;
    req_valid[1] = 1'b1;
    exp = '{1, 3, 1, 3};
    n = 0;
    for (int c = 0; c < 30 && n < exp.size(); c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_tid !== 2'(exp[n])) begin failures++; $display("FAIL wrap_tid[%0d]: got %0d want %0d", n, out_tid, exp[n]); end
        sb_take(int'(out_tid), ok, eb);
        checks++;
        if (!ok || ob !== eb) begin failures++; $display("FAIL wrap_data[%0d]: got %h want %h", n, ob, eb); end
        n++;
        if (n == 1) begin
          hold = 4'b1010;
          req_valid = 4'b1010;
        end
      end
      tick();
    end
    checks++;
    if (n != exp.size()) begin failures++; $display("FAIL wrap_timeout: got %0d issues want %0d", n, exp.size()); end
    hold = '0; req_valid = '0;
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        sb_take(int'(out_tid), ok, eb);
        checks++;
        if (!ok || ob !== eb) begin failures++; $display("FAIL wrap_drain: tid %0d got %h want %h", out_tid, ob, eb); end
      end
      tick();
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL wrap_sb_left: got %0d want 0", sbq.size()); end
  endtask

  task automatic test_midop_reset();
    int exp[$];
    int n, stale;
    bit ok;
    issue_bundle_t eb;
    do_reset();
    out_ready = 1'b0;
    req_valid = '1;
    tick();
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_tid !== 2'd0) begin failures++; $display("FAIL mid_setup: got v=%b tid=%0d want 1/0", out_valid, out_tid); end
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ready: got %b want 0001", req_ready); end
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    sbq.delete();
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    req_valid = 4'b1001;
    exp = '{0, 3};
    n = 0;
    for (int c = 0; c < 15 && n < exp.size(); c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_tid !== 2'(exp[n])) begin failures++; $display("FAIL mid_ptr_tid[%0d]: got %0d want %0d", n, out_tid, exp[n]); end
        sb_take(int'(out_tid), ok, eb);
        checks++;
        if (!ok || ob !== eb) begin failures++; $display("FAIL mid_data[%0d]: got %h want %h", n, ob, eb); end
        n++;
      end
      tick();
    end
    checks++;
    if (n != exp.size()) begin failures++; $display("FAIL mid_timeout: got %0d issues want %0d", n, exp.size()); end
  endtask

`ifdef FPU_ARB_PERF_EN
  task automatic test_counters();
    do_reset();
    sb_en = 1'b0;
    hold = 4'b0010; req_valid = 4'b0010; out_ready = 1'b1;
    for (int c = 0; c < 70010; c++) tick();
    checks++;
    if (grant_cnt[31:16] !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat: got %h want ffff", grant_cnt[31:16]); end
    checks++;
    if (grant_cnt[15:0] !== 16'h0000 || grant_cnt[63:32] !== 32'h0) begin failures++; $display("FAIL cnt_other: got %h want 0", grant_cnt); end
    checks++;
    if (stall_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_stall: got %h want 0", stall_cnt); end
    hold = '0; req_valid = '0;
    sb_en = 1'b1;
  endtask
`endif

  initial begin
    checks = 0; failures = 0; sb_en = 1'b1;
    clrn = 1'b0; out_ready = 1'b0; req_valid = '0; hold = '0;
    req_fd = '0; req_fc = '0; req_wf = '0; req_dfa = '0; req_dfb = '0;
    for (int i = 0; i < NT; i++) begin
      seq[i] = 0;
      cur[i] = mk(i, 0);
      apply(i);
    end
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap_skip();
    test_midop_reset();
`ifdef FPU_ARB_PERF_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
